// File: rtl/sound_mix.sv
// sound_mix: mixes YM2151 stereo with the Z80 sample DAC using per-source gain,
// saturation and an optional one-pole low-pass, emitting one stereo sample per tick.
module sound_mix #(
  parameter int SAMPLE_DIV     = 667,
  parameter int LPF_SHIFT      = 2,
  parameter int DAC_IDLE_TICKS = 4800
) (
  input  logic        CLK_32M,
  input  logic        RESET,
  input  logic [15:0] FM_L,
  input  logic [15:0] FM_R,
  input  logic        FM_CE,
  input  logic        DAC_WR,
  input  logic [7:0]  DAC_DIN,
  input  logic [3:0]  FM_VOL,
  input  logic [3:0]  DAC_VOL,
  output logic [15:0] AUDIO_L,
  output logic [15:0] AUDIO_R,
  output logic        SAMPLE_STB
);

  localparam int DIV_W  = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int IDLE_W = (DAC_IDLE_TICKS > 0) ? $clog2(DAC_IDLE_TICKS + 1) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(DAC_IDLE_TICKS);
  localparam logic [7:0]        DAC_MID  = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LF   = 3'd1,
    ST_LD   = 3'd2,
    ST_RF   = 3'd3,
    ST_RD   = 3'd4,
    ST_SAT  = 3'd5,
    ST_OUT  = 3'd6
  } state_t;

  function automatic logic [15:0] sat16(input logic signed [21:0] v);
    logic [15:0] r;
    if (v > 22'sd32767) begin
      r = 16'h7FFF;
    end else if (v < -22'sd32768) begin
      r = 16'h8000;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

  // One-pole low-pass step; the result stays between x and y so no clipping is needed.
  function automatic logic [15:0] lpf16(input logic [15:0] x, input logic [15:0] y);
    logic signed [17:0] xs;
    logic signed [17:0] ys;
    logic signed [17:0] diff;
    logic signed [17:0] yn;
    xs   = 18'(signed'(x));
    ys   = 18'(signed'(y));
    diff = xs - ys;
    yn   = ys + (diff >>> LPF_SHIFT);
    return yn[15:0];
  endfunction

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [15:0]       fm_l_hold_q, fm_l_hold_d, fm_r_hold_q, fm_r_hold_d;
  logic [7:0]        dac_q, dac_d;
  logic [15:0]       snap_fm_l_q, snap_fm_l_d, snap_fm_r_q, snap_fm_r_d;
  logic [7:0]        snap_dac_q, snap_dac_d;
  logic [3:0]        snap_fm_vol_q, snap_fm_vol_d, snap_dac_vol_q, snap_dac_vol_d;
  state_t            state_q, state_d;
  logic signed [21:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [15:0]       audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic              stb_q, stb_d;

  logic              tick_s;
  logic              load_s;
  logic signed [15:0] dac_val_s;
  logic signed [15:0] mul_a_s;
  logic signed [4:0]  mul_b_s;
  logic signed [20:0] prod_s;

  // Sample-rate divider, FM hold registers, DAC register with idle decay, snapshot.
  always_comb begin
    tick_s      = (div_q == DIV_LAST);
    load_s      = tick_s && (state_q == ST_IDLE);
    div_d       = tick_s ? '0 : div_q + DIV_W'(1);
    fm_l_hold_d = FM_CE ? FM_L : fm_l_hold_q;
    fm_r_hold_d = FM_CE ? FM_R : fm_r_hold_q;
    dac_d       = dac_q;
    idle_d      = idle_q;
    // A write in the same cycle as a tick overrides both the decay step and the idle increment.
    if (DAC_WR) begin
      dac_d  = DAC_DIN;
      idle_d = '0;
    end else if (tick_s) begin
      if (idle_q == IDLE_MAX) begin
        if (dac_q > DAC_MID) begin
          dac_d = dac_q - 8'd1;
        end else if (dac_q < DAC_MID) begin
          dac_d = dac_q + 8'd1;
        end else begin
          dac_d = dac_q;
        end
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end else begin
      dac_d  = dac_q;
      idle_d = idle_q;
    end
    if (load_s) begin
      snap_fm_l_d    = fm_l_hold_q;
      snap_fm_r_d    = fm_r_hold_q;
      snap_dac_d     = dac_q;
      snap_fm_vol_d  = FM_VOL;
      snap_dac_vol_d = DAC_VOL;
    end else begin
      snap_fm_l_d    = snap_fm_l_q;
      snap_fm_r_d    = snap_fm_r_q;
      snap_dac_d     = snap_dac_q;
      snap_fm_vol_d  = snap_fm_vol_q;
      snap_dac_vol_d = snap_dac_vol_q;
    end
  end

  // Sequencer next state: one multiply per state, then saturate and present.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = load_s ? ST_LF : ST_IDLE;
      ST_LF:   state_d = ST_LD;
      ST_LD:   state_d = ST_RF;
      ST_RF:   state_d = ST_RD;
      ST_RD:   state_d = ST_SAT;
      ST_SAT:  state_d = ST_OUT;
      ST_OUT:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Shared multiplier, accumulators, and the saturate/filter/output stage.
  always_comb begin
    dac_val_s = signed'({~snap_dac_q[7], snap_dac_q[6:0], 8'h00});
    mul_a_s   = 16'sd0;
    mul_b_s   = 5'sd0;
    case (state_q)
      ST_LF: begin
        mul_a_s = signed'(snap_fm_l_q);
        mul_b_s = signed'({1'b0, snap_fm_vol_q});
      end
      ST_RF: begin
        mul_a_s = signed'(snap_fm_r_q);
        mul_b_s = signed'({1'b0, snap_fm_vol_q});
      end
      ST_LD, ST_RD: begin
        mul_a_s = dac_val_s;
        mul_b_s = signed'({1'b0, snap_dac_vol_q});
      end
      default: begin
        mul_a_s = 16'sd0;
        mul_b_s = 5'sd0;
      end
    endcase
    prod_s  = 21'(mul_a_s) * 21'(mul_b_s);
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    case (state_q)
      ST_LF:   acc_l_d = 22'(prod_s);
      ST_LD:   acc_l_d = acc_l_q + 22'(prod_s);
      ST_RF:   acc_r_d = 22'(prod_s);
      ST_RD:   acc_r_d = acc_r_q + 22'(prod_s);
      default: begin
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
      end
    endcase
    // The output registers double as the filter state, loaded as the FSM enters OUT.
    if (state_q == ST_SAT) begin
      audio_l_d = lpf16(sat16(acc_l_q >>> 3), audio_l_q);
      audio_r_d = lpf16(sat16(acc_r_q >>> 3), audio_r_q);
      stb_d     = 1'b1;
    end else begin
      audio_l_d = audio_l_q;
      audio_r_d = audio_r_q;
      stb_d     = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK_32M or posedge RESET) begin
    if (RESET) begin
      div_q          <= '0;
      idle_q         <= '0;
      fm_l_hold_q    <= 16'h0000;
      fm_r_hold_q    <= 16'h0000;
      dac_q          <= DAC_MID;
      snap_fm_l_q    <= 16'h0000;
      snap_fm_r_q    <= 16'h0000;
      snap_dac_q     <= DAC_MID;
      snap_fm_vol_q  <= 4'h0;
      snap_dac_vol_q <= 4'h0;
      state_q        <= ST_IDLE;
      acc_l_q        <= 22'sd0;
      acc_r_q        <= 22'sd0;
      audio_l_q      <= 16'h0000;
      audio_r_q      <= 16'h0000;
      stb_q          <= 1'b0;
    end else begin
      div_q          <= div_d;
      idle_q         <= idle_d;
      fm_l_hold_q    <= fm_l_hold_d;
      fm_r_hold_q    <= fm_r_hold_d;
      dac_q          <= dac_d;
      snap_fm_l_q    <= snap_fm_l_d;
      snap_fm_r_q    <= snap_fm_r_d;
      snap_dac_q     <= snap_dac_d;
      snap_fm_vol_q  <= snap_fm_vol_d;
      snap_dac_vol_q <= snap_dac_vol_d;
      state_q        <= state_d;
      acc_l_q        <= acc_l_d;
      acc_r_q        <= acc_r_d;
      audio_l_q      <= audio_l_d;
      audio_r_q      <= audio_r_d;
      stb_q          <= stb_d;
    end
  end

  assign AUDIO_L    = audio_l_q;
  assign AUDIO_R    = audio_r_q;
  assign SAMPLE_STB = stb_q;

endmodule

// File: tb/tb_sound_mix.sv
// tb_sound_mix: drives two sound_mix instances (filter bypassed and LPF_SHIFT=2) with
// directed and random stimulus and compares every cycle against a sample-level model.
module tb_sound_mix;

  localparam int DIV  = 667;
  localparam int IDLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fm_l = 16'h0000;
  logic [15:0] fm_r = 16'h0000;
  logic        fm_ce = 1'b0;
  logic        dac_wr = 1'b0;
  logic [7:0]  dac_din = 8'h00;
  logic [3:0]  fm_vol = 4'h0;
  logic [3:0]  dac_vol = 4'h0;
  logic [15:0] l0, r0, l2, r2;
  logic        stb0, stb2;

  always #5 clk = ~clk;

  sound_mix #(.SAMPLE_DIV(DIV), .LPF_SHIFT(0), .DAC_IDLE_TICKS(IDLE)) u_flat (
    .CLK_32M(clk), .RESET(rst), .FM_L(fm_l), .FM_R(fm_r), .FM_CE(fm_ce),
    .DAC_WR(dac_wr), .DAC_DIN(dac_din), .FM_VOL(fm_vol), .DAC_VOL(dac_vol),
    .AUDIO_L(l0), .AUDIO_R(r0), .SAMPLE_STB(stb0));

  sound_mix #(.SAMPLE_DIV(DIV), .LPF_SHIFT(2), .DAC_IDLE_TICKS(IDLE)) u_lpf (
    .CLK_32M(clk), .RESET(rst), .FM_L(fm_l), .FM_R(fm_r), .FM_CE(fm_ce),
    .DAC_WR(dac_wr), .DAC_DIN(dac_din), .FM_VOL(fm_vol), .DAC_VOL(dac_vol),
    .AUDIO_L(l2), .AUDIO_R(r2), .SAMPLE_STB(stb2));

  int checks = 0;
  int errors = 0;

  // Reference model state: held inputs, DAC byte, ticks since last write, filter state.
  int   m_hold_l = 0, m_hold_r = 0, m_dac = 128, m_idle = 0;
  int   y2_l = 0, y2_r = 0;
  int   exp_l0 = 0, exp_r0 = 0, exp_l2 = 0, exp_r2 = 0;
  logic exp_stb = 1'b0;
  int   pend_edge = -1, pl0 = 0, pr0 = 0, pl2 = 0, pr2 = 0;
  int   edge_cnt = 0, first_stb = -1, last_stb = -1;
  logic do_rst = 1'b1, do_ce = 1'b0, do_wr = 1'b0, rand_mode = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  function automatic int mix(input int fm, input int dac, input int fv, input int dv);
    int s;
    s = (fm * fv + (dac - 128) * 256 * dv) >>> 3;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  // Applies the clock edge about to happen, using the inputs now being driven.
  task automatic model_edge();
    int xl, xr;
    if (rst) begin
      m_hold_l = 0; m_hold_r = 0; m_dac = 128; m_idle = 0; y2_l = 0; y2_r = 0;
      exp_l0 = 0; exp_r0 = 0; exp_l2 = 0; exp_r2 = 0; exp_stb = 1'b0;
      pend_edge = -1; edge_cnt = 0; first_stb = -1; last_stb = -1;
    end else begin
      exp_stb = 1'b0;
      if (edge_cnt == pend_edge) begin
        exp_stb = 1'b1;
        exp_l0 = pl0; exp_r0 = pr0; exp_l2 = pl2; exp_r2 = pr2;
        pend_edge = -1;
      end
      if (edge_cnt % DIV == DIV - 1) begin
        xl = mix(m_hold_l, m_dac, int'(fm_vol), int'(dac_vol));
        xr = mix(m_hold_r, m_dac, int'(fm_vol), int'(dac_vol));
        pl0 = xl; pr0 = xr;
        y2_l = y2_l + ((xl - y2_l) >>> 2);
        y2_r = y2_r + ((xr - y2_r) >>> 2);
        pl2 = y2_l; pr2 = y2_r;
        pend_edge = edge_cnt + 5;
        if (m_idle < IDLE) m_idle++;
        else if (m_dac > 128) m_dac--;
        else if (m_dac < 128) m_dac++;
      end
      if (dac_wr) begin
        m_dac = int'(dac_din);
        m_idle = 0;
      end
      if (fm_ce) begin
        m_hold_l = int'(signed'(fm_l));
        m_hold_r = int'(signed'(fm_r));
      end
      edge_cnt++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (stb0 === 1'b1) begin
      if (first_stb < 0) first_stb = edge_cnt;
      if (last_stb >= 0) check_val("period", edge_cnt - last_stb, DIV);
      last_stb = edge_cnt;
    end
    check_val("stb_flat", stb0, exp_stb);
    check_val("stb_lpf", stb2, exp_stb);
    if (exp_stb || (edge_cnt % 64) == 0) begin
      check_val("flat_l", l0, exp_l0 & 32'hFFFF);
      check_val("flat_r", r0, exp_r0 & 32'hFFFF);
      check_val("lpf_l", l2, exp_l2 & 32'hFFFF);
      check_val("lpf_r", r2, exp_r2 & 32'hFFFF);
    end
    rst = do_rst;
    if (rand_mode) begin
      fm_ce = ($urandom_range(0, 7) == 0);
      if (fm_ce) begin
        fm_l = 16'($urandom);
        fm_r = 16'($urandom);
      end
      dac_wr = ($urandom_range(0, 299) == 0);
      dac_din = 8'($urandom);
      if ($urandom_range(0, 499) == 0) fm_vol = 4'($urandom);
      if ($urandom_range(0, 499) == 0) dac_vol = 4'($urandom);
    end else begin
      fm_ce = do_ce;
      dac_wr = do_wr;
      do_ce = 1'b0;
      do_wr = 1'b0;
    end
    model_edge();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fm_pulse(input logic [15:0] vl, input logic [15:0] vr);
    fm_l = vl; fm_r = vr; do_ce = 1'b1; step();
  endtask

  task automatic dac_pulse(input logic [7:0] v);
    dac_din = v; do_wr = 1'b1; step();
  endtask

  // Steps until the next edge is the one where the divider sits at phase k.
  task automatic align(input int k);
    for (int i = 0; i < DIV && (edge_cnt % DIV) != k; i++) step();
  endtask

  initial begin
    do_rst = 1'b1;
    run(2);
    do_rst = 1'b0;
    run(2 * DIV + 12);
    check_val("first_stb", first_stb, 672);

    // LPF step response from zero at unity gain.
    fm_vol = 4'd8; dac_vol = 4'd0;
    fm_pulse(16'h4000, 16'h4000);
    run(4 * DIV);

    // Unity FM pass-through.
    fm_pulse(16'h1000, 16'hF000);
    run(2 * DIV);

    // Positive then negative saturation.
    fm_vol = 4'd15; dac_vol = 4'd15;
    fm_pulse(16'h7000, 16'h7000);
    dac_pulse(8'hFF);
    run(2 * DIV);
    fm_pulse(16'h9000, 16'h9000);
    dac_pulse(8'h00);
    run(2 * DIV);

    // DAC only, including a write coincident with a tick.
    fm_vol = 4'd0; dac_vol = 4'd8;
    dac_pulse(8'hC0);
    run(2 * DIV);
    align(DIV - 1);
    dac_pulse(8'h40);
    run(2 * DIV);

    // Idle decay toward centre, then a write restarting the count.
    dac_pulse(8'h84);
    run(9 * DIV);
    dac_pulse(8'h7C);
    run(7 * DIV);

    rand_mode = 1'b1;
    run(20 * DIV);
    rand_mode = 1'b0;

    // Reset in the middle of the multiply sequence.
    align(DIV - 1);
    run(3);
    do_rst = 1'b1;
    run(3);
    do_rst = 1'b0;
    run(DIV);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_mix.md
# sound_mix

Downstream audio output stage for the sound board. Takes the YM2151 stereo output and the Z80-written 8-bit sample DAC, and applies per-source volume, saturation and an optional one-pole low-pass. It emits 16-bit signed stereo at a fixed output rate derived from the 32 MHz system clock, together with a one-cycle sample strobe for the top-level audio sink.

## Interface
Parameters:
- SAMPLE_DIV, 667: CLK_32M cycles per output sample (about 47.98 kHz); must be at least 8.
- LPF_SHIFT, 2: low-pass coefficient 2^-LPF_SHIFT; 0 bypasses the filter.
- DAC_IDLE_TICKS, 4800: number of output ticks without a DAC write before the DAC decays toward centre.

Ports:
- CLK_32M, in, 1: system clock; single clock domain.
- RESET, in, 1: asynchronous, active-high reset.
- FM_L, in, 16: signed YM2151 left sample.
- FM_R, in, 16: signed YM2151 right sample.
- FM_CE, in, 1: FM sample-valid strobe (the YM2151 clock enable).
- DAC_WR, in, 1: one-cycle Z80 write strobe to the DAC port.
- DAC_DIN, in, 8: unsigned DAC byte; 0x80 is silence.
- FM_VOL, in, 4: FM gain in steps of 1/8 (0 = mute, 8 = unity, 15 = 1.875).
- DAC_VOL, in, 4: DAC gain, same scale as FM_VOL.
- AUDIO_L, out, 16: signed mixed left output.
- AUDIO_R, out, 16: signed mixed right output.
- SAMPLE_STB, out, 1: one-cycle pulse when AUDIO_L/AUDIO_R update.

## Operation
- Reset values: AUDIO_L=0, AUDIO_R=0, SAMPLE_STB=0. Internally: FM holds=0, DAC register=0x80, divider=0, idle counter=0, FSM=IDLE, LPF state=0.
- FM capture:
  - On FM_CE=1, latch FM_L and FM_R into the hold registers.
  - Otherwise the hold registers keep their values.
- DAC write:
  - On DAC_WR=1, the DAC register is loaded with DAC_DIN and the idle counter is cleared.
  - The signed DAC contribution is (DAC register − 128) << 8.
- Tick: the divider counts 0..SAMPLE_DIV−1 and wraps; the tick fires when the divider equals SAMPLE_DIV−1.
- On tick, snapshot the FM holds, the DAC value, FM_VOL and DAC_VOL into working registers. Later input changes do not affect the sample in flight.
- FSM, one shared signed 16x5 multiplier, one state per cycle:
  - IDLE: wait for tick, then go to LF.
  - LF: accL = FM_L*FM_VOL.
  - LD: accL += dac*DAC_VOL.
  - RF: accR = FM_R*FM_VOL.
  - RD: accR += dac*DAC_VOL.
  - SAT: arithmetic shift right by 3, then saturate to [−32768, 32767].
  - OUT: apply the LPF, drive the outputs, assert SAMPLE_STB, return to IDLE.
- Width rules: products are 21 bits signed; accumulators are 22 bits signed, so no overflow is possible before saturation.
- LPF: y <= y + ((x − y) >>> LPF_SHIFT), computed in 18-bit signed arithmetic. The result is already within range, so no further clipping is needed. With LPF_SHIFT=0, y = x.
- DAC idle decay:
  - The idle counter increments on every tick and saturates at DAC_IDLE_TICKS.
  - Once it has saturated, each tick steps the DAC register one LSB toward 0x80, and stops at 0x80.
- Simultaneous events:
  - DAC_WR and tick in the same cycle: the snapshot takes the pre-write DAC value. The write lands and the idle counter clears; the clear wins over the increment.
  - FM_CE and tick in the same cycle: the snapshot takes the previous hold value.
- A tick arriving while the FSM is not in IDLE cannot happen given SAMPLE_DIV ≥ 8. If it does, the tick is ignored.
- RESET asserted mid-sequence: the block returns to reset values immediately and no strobe is emitted.

## Timing
- Tick at cycle T:
  - Snapshot at T.
  - FSM is in LF at T+1.
  - AUDIO_L/AUDIO_R update and SAMPLE_STB=1 at T+6, exactly one cycle wide.
- Outputs are stable for SAMPLE_DIV cycles between strobes.
- FM latency: FM_CE to the snapshot is one tick period at worst, then 6 cycles to the output.
- First strobe after RESET deasserts: cycle SAMPLE_DIV+5, counted from the first active clock edge numbered 0.
- Strobe period is exactly SAMPLE_DIV cycles.

## Test plan
- Reset and rate: release RESET with all inputs 0 → first SAMPLE_STB at cycle 672; strobes every 667 cycles; outputs stay 0.
- Unity FM, LPF_SHIFT=0: FM_L=0x1000, FM_R=0xF000, FM_VOL=8, DAC_VOL=0, FM_CE pulsed → AUDIO_L=0x1000, AUDIO_R=0xF000 at the strobe 6 cycles after the next tick.
- Saturation: FM_L=0x7000, FM_VOL=15, DAC=0xFF, DAC_VOL=15 → AUDIO_L=0x7FFF. Repeat with FM_L=0x9000 and DAC=0x00 → AUDIO_L=0x8000.
- DAC mix: FM_VOL=0, DAC_VOL=8, DAC_WR with 0xC0 → both channels 0x4000. Then DAC_WR coincident with a tick → that sample still uses the old value; the next sample uses the new one.
- Idle decay, DAC_IDLE_TICKS=4: write 0x84 → after 4 more ticks the value steps through 0x83, 0x82, 0x81, 0x80, one step per tick, then holds at 0x80. A new write restarts the count.
- LPF, LPF_SHIFT=2: step input 0→0x4000 at unity gain → outputs 0x1000, 0x1C00, 0x2500, … converging monotonically. RESET asserted mid-FSM → no strobe, outputs 0.
